// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: datapath width, NOP encoding, reset PC and fetch FSM states.
`default_nettype none
package fetch_pkg;
  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] C_NOP_INST = 32'h0000_0013;
  localparam logic [XLEN-1:0] C_RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_DROP = 3'd4
  } fetch_state_t;
endpackage
`default_nettype wire

// File: rtl/fetch.sv
// Instruction-fetch stage: one outstanding ready/valid read, single-entry instruction buffer,
// redirect on FLUSH with discard of any stale in-flight response.
`default_nettype none
module fetch
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = C_RESET_PC_DEFAULT
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            STALL,
  input  logic            MEM_WAIT,
  input  logic            FLUSH,
  input  logic [XLEN-1:0] NEW_PC,
  output logic            INST_RDEN,
  output logic [XLEN-1:0] INST_RADDR,
  input  logic            INST_RREADY,
  input  logic            INST_RVALID,
  input  logic [XLEN-1:0] INST_RDATA,
  output logic [XLEN-1:0] FETCH_PC,
  output logic [XLEN-1:0] FETCH_INST
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] buf_pc_q, buf_pc_d;
  logic [XLEN-1:0] buf_inst_q, buf_inst_d;
  logic            buf_valid_q, buf_valid_d;

  logic w_consume;
  logic w_flush;
  logic w_outstanding;

  // MEM_WAIT freezes the whole hand-off to decode, including redirects.
  assign w_consume = !STALL && !MEM_WAIT;
  assign w_flush   = FLUSH && !MEM_WAIT;

  // A request is still owed a response after this edge; a redirect must then drain it.
  assign w_outstanding = ((state_q == S_WAIT) && !INST_RVALID) ||
                         ((state_q == S_REQ)  &&  INST_RREADY) ||
                         ((state_q == S_DROP) && !INST_RVALID);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      buf_pc_q    <= '0;
      buf_inst_q  <= C_NOP_INST;
      buf_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_pc_q    <= buf_pc_d;
      buf_inst_q  <= buf_inst_d;
      buf_valid_q <= buf_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_pc_d    = buf_pc_q;
    buf_inst_d  = buf_inst_q;
    buf_valid_d = buf_valid_q;

    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (INST_RREADY) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (INST_RVALID) begin
          buf_pc_d    = pc_q;
          buf_inst_d  = INST_RDATA;
          buf_valid_d = 1'b1;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_consume) begin
          buf_valid_d = 1'b0;
          pc_d        = pc_q + 32'd4;
          state_d     = S_REQ;
        end
      end
      S_DROP: begin
        if (INST_RVALID) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase

    if (w_flush && (state_q != S_IDLE)) begin
      pc_d        = NEW_PC & ~32'd3;
      buf_valid_d = 1'b0;
      state_d     = w_outstanding ? S_DROP : S_REQ;
    end
  end

  assign INST_RDEN  = (state_q == S_REQ);
  assign INST_RADDR = pc_q;
  assign FETCH_PC   = buf_valid_q ? buf_pc_q   : '0;
  assign FETCH_INST = buf_valid_q ? buf_inst_q : C_NOP_INST;

endmodule
`default_nettype wire

// File: doc/fetch.md
# fetch

Instruction-fetch stage of the CPU pipeline, feeding the decode stage's PC/INST inputs. Holds the program counter, issues one 32-bit instruction read at a time over a ready/valid memory port, and buffers the returned word until decode consumes it. Handles branch/exception redirect (FLUSH + NEW_PC) by discarding any in-flight response. Emits a NOP bubble whenever no instruction is available.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset (bits [1:0] must be 0)
- CLK  in  1  clock, all state on posedge
- RST  in  1  asynchronous, active-high reset
- STALL  in  1  decode is holding; fetch output not consumed
- MEM_WAIT  in  1  global data-memory wait; fetch output not consumed, FLUSH ignored
- FLUSH  in  1  redirect request
- NEW_PC  in  32  redirect target, sampled with FLUSH; bits [1:0] forced to 0
- INST_RDEN  out  1  read request valid
- INST_RADDR  out  32  read address
- INST_RREADY  in  1  memory accepts request this cycle
- INST_RVALID  in  1  read data valid
- INST_RDATA  in  32  instruction word
- FETCH_PC  out  32  PC of buffered instruction; 0 when no instruction
- FETCH_INST  out  32  buffered instruction; 32'h0000_0013 (NOP) when no instruction

## Operation
- Registers: pc[31:0], buf_pc, buf_inst, buf_valid, state ∈ {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DROP}.
- consume = !STALL && !MEM_WAIT; flush = FLUSH && !MEM_WAIT (same priority as decode: MEM_WAIT > FLUSH > STALL).
- S_IDLE: reset state; next cycle → S_REQ.
- S_REQ: INST_RDEN=1, INST_RADDR=pc. On INST_RREADY → S_WAIT.
- S_WAIT: on INST_RVALID: buf_pc<=pc, buf_inst<=INST_RDATA, buf_valid<=1 → S_HOLD.
- S_HOLD: FETCH_* drive buffer. On consume: buf_valid<=0, pc<=pc+4 (mod 2^32) → S_REQ.
- S_DROP: waits for the stale response; on INST_RVALID, data discarded → S_REQ.
- flush (any state except S_IDLE, overrides all other transitions): pc<=NEW_PC&~3, buf_valid<=0; next state S_DROP if a request is outstanding after this edge (S_WAIT without RVALID, S_REQ with RREADY, S_DROP without RVALID), otherwise S_REQ.
- At most one request outstanding; INST_RDEN/INST_RADDR stable while waiting for RREADY (unless flush).
- Memory responses arrive in order, ≥1 cycle after acceptance; RVALID outside S_WAIT/S_DROP is a protocol error (ignored).

## Timing
- Reset (asynchronous): state=S_IDLE, pc=RESET_PC, buf_valid=0; INST_RDEN=0, INST_RADDR=RESET_PC, FETCH_PC=0, FETCH_INST=32'h0000_0013.
- First request: INST_RDEN=1 in 2nd cycle after RST deasserts.
- Latency: RREADY at edge N, RVALID at edge N+k → FETCH_INST valid from edge N+k; decode captures at first edge with consume.
- Best-case throughput with 1-cycle memory: one instruction per 3 cycles (REQ, WAIT, HOLD).
- FETCH_* are registered-buffer outputs; no combinational path from INST_RDATA.
- flush with MEM_WAIT=1: no effect; the controller holds FLUSH until MEM_WAIT falls.
- flush and consume in same cycle: flush wins; buffered instruction dropped, pc not incremented.
- Reset mid-transaction: state cleared; the memory is also reset, so no stale response is expected.

## Structure
- Shared package: state encoding, NOP constant 32'h0000_0013, RESET_PC default, 32-bit XLEN constant (also used by decode).
- Single module; no sub-module. PC-increment and buffer logic are too small to split.

## Test plan
- Reset, RESET_PC=0, RREADY=1, 1-cycle memory returning 0x00500093 → RDEN at cycle 2, FETCH_PC=0/FETCH_INST=0x00500093 from cycle 4, next RADDR=4.
- STALL=1 for 5 cycles while in S_HOLD → FETCH_* stable, RDEN=0, pc unchanged; after release, RADDR=pc+4.
- RREADY low 3 cycles → RDEN and RADDR held constant until accepted.
- FLUSH, NEW_PC=0x100 while in S_WAIT, response 2 cycles later → response discarded (FETCH_INST stays NOP), next RADDR=0x100.
- FLUSH with MEM_WAIT=1 → ignored; FLUSH with NEW_PC=0x203 → RADDR=0x200.
- pc=0xFFFF_FFFC consumed → next RADDR=0x0000_0000.
